// File: rtl/keypad_entry_accumulator.sv
// Collects keypad digit events into a BCD entry buffer with backspace/clear editing,
// and on ENTER converts the buffer to binary one digit per cycle (acc = acc*10 + digit).
module keypad_entry_accumulator #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_flag,
  input  logic [3:0]                key_value,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [CNT_WIDTH-1:0]      digit_count,
  output logic [BIN_WIDTH-1:0]      value_bin,
  output logic                      value_valid,
  output logic                      busy,
  output logic                      overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]     TOP_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [BIN_WIDTH-1:0]    r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic [BIN_WIDTH-1:0]    r_value;
  logic                    r_valid;
  logic                    r_overflow;

  logic                    w_key_digit;
  logic                    w_key_enter;
  logic                    w_key_back;
  logic                    w_key_clear;
  logic                    w_buf_full;
  logic                    w_buf_empty;
  logic                    w_start;
  logic                    w_last_iter;
  logic                    w_busy;
  logic [4*NUM_DIGITS-1:0] w_shift_up;
  logic [4*NUM_DIGITS-1:0] w_shift_down;
  logic [3:0]              w_cur_digit;
  logic [BIN_WIDTH-1:0]    w_acc_x10;
  logic [BIN_WIDTH-1:0]    w_acc_next;

  assign w_key_digit = (key_value <= 4'd9);
  assign w_key_enter = (key_value == 4'd10);
  assign w_key_back  = (key_value == 4'd11);
  assign w_key_clear = (key_value == 4'd12);
  assign w_buf_full  = (r_count >= MAX_COUNT);
  assign w_buf_empty = (r_count == '0);
  assign w_start     = key_flag & w_key_enter & ~w_buf_empty;
  assign w_last_iter = (r_idx == '0);

  // Nibble 0 is the newest digit: entering shifts every nibble up, backspace shifts down.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
      if (gi == 0) begin : g_low
        assign w_shift_up[3:0] = key_value;
      end else begin : g_up
        assign w_shift_up[4*gi +: 4] = r_digits[4*(gi-1) +: 4];
      end
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_shift_down[4*gi +: 4] = 4'd0;
      end else begin : g_down
        assign w_shift_down[4*gi +: 4] = r_digits[4*(gi+1) +: 4];
      end
    end
  endgenerate

  assign w_cur_digit = r_digits[{r_idx, 2'b00} +: 4];
  assign w_acc_x10   = (r_acc << 3) + (r_acc << 1);
  assign w_acc_next  = w_acc_x10 + {{(BIN_WIDTH-4){1'b0}}, w_cur_digit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (w_last_iter) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:    w_busy = 1'b0;
      S_CONVERT: w_busy = 1'b1;
      default:   w_busy = 1'b0;
    endcase
  end

  // Buffer editing and the conversion datapath; key events are ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_flag) begin
            if (w_key_digit) begin
              if (!w_buf_full) begin
                r_digits <= w_shift_up;
                r_count  <= r_count + CNT_WIDTH'(1);
              end else begin
                r_overflow <= 1'b1;
              end
            end else if (w_key_back) begin
              if (!w_buf_empty) begin
                r_digits <= w_shift_down;
                r_count  <= r_count - CNT_WIDTH'(1);
              end
            end else if (w_key_clear) begin
              r_digits <= '0;
              r_count  <= '0;
            end else if (w_start) begin
              r_acc <= '0;
              r_idx <= TOP_IDX;
            end
          end
        end
        S_CONVERT: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - IDX_W'(1);
          if (w_last_iter) begin
            r_value  <= w_acc_next;
            r_valid  <= 1'b1;
            r_digits <= '0;
            r_count  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign value_bin   = r_value;
  assign value_valid = r_valid;
  assign busy        = w_busy;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_entry_accumulator.sv
// Self-checking bench: a table of editing vectors, hand sequences for conversion corner
// cases, and random key streams compared against a queue-based decimal model.
module tb_keypad_entry_accumulator;

  localparam int N    = 4;
  localparam int BW   = 14;
  localparam int CW   = 3;

  logic          clk;
  logic          rst;
  logic          key_flag;
  logic [3:0]    key_value;
  logic [4*N-1:0] digits;
  logic [CW-1:0] digit_count;
  logic [BW-1:0] value_bin;
  logic          value_valid;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  keypad_entry_accumulator #(.NUM_DIGITS(N), .BIN_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_value(key_value),
    .digits(digits), .digit_count(digit_count), .value_bin(value_bin),
    .value_valid(value_valid), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] dig;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[20];
  int   model_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // All tasks start and end at a falling edge; outputs are sampled there.
  task automatic key_press(input logic [3:0] k);
    key_flag  = 1'b1;
    key_value = k;
    @(negedge clk);
    key_flag  = 1'b0;
  endtask

  task automatic do_enter(input longint exp_val);
    key_press(4'hA);
    for (int i = 1; i <= N; i++) begin
      chk("busy_during_convert", busy, 1);
      chk("valid_during_convert", value_valid, 0);
      @(negedge clk);
    end
    chk("valid_pulse", value_valid, 1);
    chk("busy_after_convert", busy, 0);
    chk("value_bin", value_bin, exp_val);
    chk("digits_cleared", digits, 0);
    chk("count_cleared", digit_count, 0);
  endtask

  function automatic longint model_digits();
    longint v = 0;
    foreach (model_q[i]) v = (v << 4) | model_q[i];
    return v;
  endfunction

  function automatic longint model_value();
    longint v = 0;
    foreach (model_q[i]) v = (v * 10 + model_q[i]) % (64'd1 << BW);
    return v;
  endfunction

  initial begin
    tbl[0]  = '{4'hC, 16'h0000, 0, 1'b0};
    tbl[1]  = '{4'h9, 16'h0009, 1, 1'b0};
    tbl[2]  = '{4'h8, 16'h0098, 2, 1'b0};
    tbl[3]  = '{4'h7, 16'h0987, 3, 1'b0};
    tbl[4]  = '{4'h6, 16'h9876, 4, 1'b0};
    tbl[5]  = '{4'h5, 16'h9876, 4, 1'b1};
    tbl[6]  = '{4'hB, 16'h0987, 3, 1'b0};
    tbl[7]  = '{4'hD, 16'h0987, 3, 1'b0};
    tbl[8]  = '{4'hC, 16'h0000, 0, 1'b0};
    tbl[9]  = '{4'h4, 16'h0004, 1, 1'b0};
    tbl[10] = '{4'h2, 16'h0042, 2, 1'b0};
    tbl[11] = '{4'hB, 16'h0004, 1, 1'b0};
    tbl[12] = '{4'h7, 16'h0047, 2, 1'b0};
    tbl[13] = '{4'hB, 16'h0004, 1, 1'b0};
    tbl[14] = '{4'hB, 16'h0000, 0, 1'b0};
    tbl[15] = '{4'hB, 16'h0000, 0, 1'b0};
    tbl[16] = '{4'hF, 16'h0000, 0, 1'b0};
    tbl[17] = '{4'h0, 16'h0000, 1, 1'b0};
    tbl[18] = '{4'h0, 16'h0000, 2, 1'b0};
    tbl[19] = '{4'h3, 16'h0003, 3, 1'b0};

    rst = 1'b1; key_flag = 1'b0; key_value = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_digits", digits, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_value", value_bin, 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);

    // 1,2,3,4 three cycles apart, then ENTER; a key in the valid cycle is accepted.
    for (int d = 1; d <= 4; d++) begin
      key_press(4'(d));
      repeat (2) @(negedge clk);
    end
    chk("seq1234_digits", digits, 16'h1234);
    chk("seq1234_count", digit_count, 4);
    do_enter(1234);
    key_press(4'h7);
    chk("valid_one_cycle", value_valid, 0);
    chk("key_in_valid_cycle_digits", digits, 16'h0007);
    chk("key_in_valid_cycle_count", digit_count, 1);

    for (int i = 0; i < 20; i++) begin
      key_press(tbl[i].key);
      chk($sformatf("tbl%0d_digits", i), digits, tbl[i].dig);
      chk($sformatf("tbl%0d_count", i), digit_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
      @(negedge clk);
      chk($sformatf("tbl%0d_ovf_clear", i), overflow, 0);
    end
    do_enter(3);
    @(negedge clk);

    // Full buffer then ENTER.
    foreach (tbl[i]) if (i >= 1 && i <= 4) key_press(tbl[i].key);
    do_enter(9876);
    @(negedge clk);

    // ENTER on an empty buffer does nothing.
    key_press(4'hA);
    for (int i = 0; i < N + 2; i++) begin
      chk("empty_enter_busy", busy, 0);
      chk("empty_enter_valid", value_valid, 0);
      @(negedge clk);
    end

    // Key 5 strobed while converting "1" is dropped.
    key_press(4'h1);
    key_press(4'hA);
    for (int i = 1; i <= N; i++) begin
      chk("drop_busy", busy, 1);
      chk("drop_overflow", overflow, 0);
      key_flag  = (i == 2);
      key_value = 4'h5;
      @(negedge clk);
    end
    key_flag = 1'b0;
    chk("drop_valid", value_valid, 1);
    chk("drop_value", value_bin, 1);
    chk("drop_digits", digits, 0);
    chk("drop_count", digit_count, 0);
    key_press(4'hD);
    chk("keyD_digits", digits, 0);
    chk("keyD_count", digit_count, 0);

    // Reset two cycles into a conversion aborts it.
    key_press(4'h6);
    key_press(4'h6);
    key_press(4'hA);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    chk("abort_valid_pre", value_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_digits", digits, 0);
    chk("abort_count", digit_count, 0);
    chk("abort_value", value_bin, 0);
    chk("abort_busy_after", busy, 0);
    chk("abort_overflow", overflow, 0);
    for (int i = 0; i < N + 2; i++) begin
      chk("abort_no_valid", value_valid, 0);
      @(negedge clk);
    end

    // Random key streams against the decimal model.
    model_q.delete();
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [3:0] k;
      logic exp_ovf;
      r = $urandom_range(0, 23);
      k = (r < 16) ? 4'(r) : 4'($urandom_range(0, 9));
      if (k == 4'hA && model_q.size() > 0) begin
        do_enter(model_value());
        model_q.delete();
      end else begin
        exp_ovf = 1'b0;
        if (k <= 4'd9) begin
          if (model_q.size() < N) model_q.push_back(int'(k));
          else exp_ovf = 1'b1;
        end else if (k == 4'hB) begin
          if (model_q.size() > 0) void'(model_q.pop_back());
        end else if (k == 4'hC) begin
          model_q.delete();
        end
        key_press(k);
        chk("rand_digits", digits, model_digits());
        chk("rand_count", digit_count, model_q.size());
        chk("rand_overflow", overflow, exp_ovf);
        chk("rand_busy", busy, 0);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rand_pulses_clear", overflow | value_valid, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_accumulator.md
Name: keypad_entry_accumulator

Overview:
Downstream consumer of the 4x4 keypad reader. Takes its one-cycle key strobe (flag) and 4-bit key code, and assembles digit keys into a multi-digit BCD entry buffer for display. Keys B and C edit the buffer; key A commits it. On commit, a sequential multiply-by-10 converter turns the BCD buffer into a binary value and presents it with a one-cycle valid pulse.

Parameters:
NUM_DIGITS, 4, number of BCD digits in the entry buffer (2..8)
BIN_WIDTH, 14, width of the binary result; must satisfy 2^BIN_WIDTH >= 10^NUM_DIGITS
CNT_WIDTH, 3, width of digit_count; must hold the value NUM_DIGITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_flag  in  1  key strobe from keypad reader; each high cycle is one key event
key_value  in  4  key code, valid when key_flag=1
digits  out  4*NUM_DIGITS  BCD entry buffer; [3:0] is the most recently entered (least significant) digit
digit_count  out  CNT_WIDTH  number of digits currently entered (0..NUM_DIGITS)
value_bin  out  BIN_WIDTH  binary value of the last committed entry
value_valid  out  1  one-cycle pulse when value_bin updates
busy  out  1  high while a conversion is in progress
overflow  out  1  one-cycle pulse when a digit key is rejected because the buffer is full

Behaviour:
- Reset: digits=0, digit_count=0, value_bin=0, value_valid=0, busy=0, overflow=0, FSM=IDLE. Reset during CONVERT aborts the conversion with no value_valid pulse.
- Key map: codes 0-9 are digits; 10 (A)=ENTER; 11 (B)=BACKSPACE; 12 (C)=CLEAR; 13-15 are ignored with no effect.
- Edge detection is not performed here: every cycle with key_flag=1 in IDLE is one event.
- FSM states: IDLE and CONVERT.
- IDLE, digit key:
  - If digit_count < NUM_DIGITS: digits <= {digits shifted up one nibble, new digit in [3:0]}; digit_count+1.
  - Else: buffer unchanged; overflow=1 for the next cycle only.
- IDLE, BACKSPACE: if digit_count>0, digits shift down one nibble (top nibble <= 0) and digit_count-1; at count 0, no effect.
- IDLE, CLEAR: digits<=0, digit_count<=0.
- IDLE, ENTER:
  - If digit_count=0: ignored; no pulse, no state change.
  - Otherwise: go to CONVERT; busy=1 from the next cycle; accumulator<=0; digit index<=NUM_DIGITS-1.
- CONVERT: one iteration per cycle, acc <= acc*10 + digits[idx], idx from NUM_DIGITS-1 down to 0. Leading zero digits are processed normally.
- Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1) in BIN_WIDTH bits, truncated modulo 2^BIN_WIDTH.
- Completion, on the NUM_DIGITS-th iteration edge:
  - value_bin <= final acc; value_valid=1 for exactly one cycle; busy=0.
  - digits<=0, digit_count<=0; FSM<=IDLE.
- Latency: value_valid is high in the cycle exactly NUM_DIGITS cycles after the cycle where the ENTER strobe was sampled. busy is high for exactly NUM_DIGITS cycles.
- During CONVERT, all key events are dropped: no buffer change, no overflow pulse, no queuing.
- A key strobe in the same cycle value_valid is high is accepted normally, because the FSM is already in IDLE.
- value_bin holds its value until the next completed conversion or reset.
- overflow and value_valid are registered outputs and are never high for more than one consecutive cycle per event.

Test Plan:
- Reset, then keys 1,2,3,4,A as single-cycle strobes 3 cycles apart -> digits=0x1234, count=4 before A; value_valid pulses once exactly 4 cycles after the A strobe with value_bin=1234; busy high 4 cycles; then digits=0, count=0.
- Keys 9,8,7,6,5 -> 5th key rejected: overflow pulses 1 cycle, digits stay 0x9876, count=4; then A -> value_bin=9876.
- Keys 4,2,B,7 -> digits=0x0047, count=2; B,B,B -> count=0, digits=0, no underflow; A at count 0 -> no value_valid, busy stays 0.
- Keys 5,C,0,0,3,A -> value_bin=3 (leading zeros handled), digit_count before A = 3.
- Keys 1,A, then key 5 strobed during busy -> value_bin=1; the 5 is dropped, so buffer=0 after completion. Key D (13) in IDLE -> no change.
- Keys 6,6,A, with rst asserted 2 cycles into CONVERT -> no value_valid, value_bin=0, all outputs at reset values.
